// File: rtl/proc_selftest_pkg.sv
// Shared types for the on-chip instruction self-test sequencer.
// The test_entry_t layout fixes the default instruction/data width (32) and
// register index width (5); the sequencer's XLEN/REG_AW must match it.
package proc_selftest_pkg;

   localparam int ENTRY_XLEN   = 32;
   localparam int ENTRY_REG_AW = 5;

   // RISC-V canonical NOP (addi x0, x0, 0)
   localparam logic [ENTRY_XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [2:0] {
      IDLE,
      WARMUP,
      FETCH,
      ISSUE,
      WAIT_WB,
      NEXT,
      DONE
   } state_t;

   typedef struct packed {
      logic [ENTRY_XLEN-1:0]   instr;
      logic [ENTRY_REG_AW-1:0] rd;
      logic [ENTRY_XLEN-1:0]   exp;
      logic                    chk;
   } test_entry_t;

endpackage

// File: rtl/selftest_fail_log.sv
// Small synchronous failure-log FIFO with show-ahead read.
// Pushes while full are dropped and flagged in the sticky ovf output.
// DEPTH must be a power of two (pointer wrap uses the extra MSB).
module selftest_fail_log #(
   parameter int DEPTH = 8,
   parameter int W     = 38
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         rd_en,
   output logic         empty,
   output logic [W-1:0] dout,
   output logic         ovf
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem_array [DEPTH];
   logic [PW:0]  wr_ptr_reg;
   logic [PW:0]  rd_ptr_reg;
   logic         ovf_reg;
   logic         full;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                    (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = rd_en && !empty;
   assign dout    = mem_array[rd_ptr_reg[PW-1:0]];
   assign ovf     = ovf_reg;

   // Storage write; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_array[wr_ptr_reg[PW-1:0]] <= din;
      end
   end

   // Pointer and overflow bookkeeping; clr empties the log for a new run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         ovf_reg    <= 1'b0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
         end
         if (push && full) begin
            ovf_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/proc_selftest_seq.sv
// On-chip instruction self-test sequencer: walks a test table, injects one
// instruction at a time, watches the regfile writeback port and reports
// pass/fail, failure count and first-failure details.
// Optional build macro SELFTEST_FAIL_LOG_EN adds a failure log FIFO with
// ports log_rd_en / log_empty / log_data / log_ovf.
// The next table address is presented while the current entry executes, so a
// table ROM with one cycle of read latency is always ready by FETCH.
module proc_selftest_seq
   import proc_selftest_pkg::*;
#(
   parameter int NUM_TESTS   = 32,
   parameter int XLEN        = 32,
   parameter int REG_AW      = 5,
   parameter int START_DELAY = 8,
   parameter int WB_TIMEOUT  = 8,
`ifdef SELFTEST_FAIL_LOG_EN
   parameter int LOG_DEPTH   = 8,
`endif
   localparam int AW  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
   localparam int FCW = $clog2(NUM_TESTS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [AW-1:0]     tbl_addr,
   input  logic [XLEN-1:0]   tbl_instr,
   input  logic [REG_AW-1:0] tbl_rd,
   input  logic [XLEN-1:0]   tbl_exp,
   input  logic              tbl_chk,
   output logic              inj_valid,
   output logic [XLEN-1:0]   inj_instr,
   input  logic              inj_ready,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [FCW-1:0]    fail_count,
   output logic [AW-1:0]     fail_idx,
   output logic [XLEN-1:0]   fail_got,
   output logic              fail_timeout
`ifdef SELFTEST_FAIL_LOG_EN
   ,
   input  logic                 log_rd_en,
   output logic                 log_empty,
   output logic [AW+XLEN:0]     log_data,
   output logic                 log_ovf
`endif
);

   localparam int          CNT_MAX = (START_DELAY > WB_TIMEOUT) ? START_DELAY : WB_TIMEOUT;
   localparam int          CW      = $clog2(CNT_MAX + 1);
   localparam logic [AW-1:0] LAST  = AW'(NUM_TESTS - 1);

   state_t            state_reg;
   state_t            state_next;
   test_entry_t       entry_reg;
   logic [AW-1:0]     idx_reg;
   logic [AW-1:0]     tbl_addr_reg;
   logic [CW-1:0]     cnt_reg;
   logic [FCW-1:0]    fail_count_reg;
   logic [AW-1:0]     fail_idx_reg;
   logic [XLEN-1:0]   fail_got_reg;
   logic              fail_timeout_reg;

   logic              start_run;
   logic              wb_hit;
   logic              fail_ev;
   logic              fail_to;
   logic [XLEN-1:0]   fail_val;

   assign tbl_addr     = tbl_addr_reg;
   assign fail_count   = fail_count_reg;
   assign fail_idx     = fail_idx_reg;
   assign fail_got     = fail_got_reg;
   assign fail_timeout = fail_timeout_reg;
   assign pass         = done && (fail_count_reg == '0);

   // State register; reset drops inj_valid immediately via state decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode, injection outputs and per-cycle failure events
   always_comb begin
      state_next = state_reg;
      start_run  = 1'b0;
      wb_hit     = 1'b0;
      fail_ev    = 1'b0;
      fail_to    = 1'b0;
      fail_val   = '0;
      inj_valid  = 1'b0;
      inj_instr  = NOP_INSTR;
      busy       = (state_reg != IDLE) && (state_reg != DONE);
      done       = (state_reg == DONE);
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next = WARMUP;
               start_run  = 1'b1;
            end
         end
         WARMUP: begin
            if (cnt_reg == CW'(START_DELAY - 1)) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            state_next = ISSUE;
         end
         ISSUE: begin
            inj_valid = 1'b1;
            inj_instr = entry_reg.instr;
            if (inj_ready) begin
               state_next = (entry_reg.chk && (entry_reg.rd != '0)) ? WAIT_WB : NEXT;
            end
         end
         WAIT_WB: begin
            wb_hit = wb_en && (wb_rd == entry_reg.rd);
            if (wb_hit) begin
               state_next = NEXT;
               if (wb_data != entry_reg.exp) begin
                  fail_ev  = 1'b1;
                  fail_val = wb_data;
               end
            end else if (cnt_reg == CW'(WB_TIMEOUT - 1)) begin
               state_next = NEXT;
               fail_ev    = 1'b1;
               fail_to    = 1'b1;
            end
         end
         NEXT: begin
            state_next = (idx_reg == LAST) ? DONE : FETCH;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Cycle counter for warm-up and writeback timeout; restarts on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (state_next != state_reg) begin
         cnt_reg <= '0;
      end else if ((state_reg == WARMUP) || (state_reg == WAIT_WB)) begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   // Table walk: latch the entry in FETCH and prefetch the following address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_reg    <= '0;
         idx_reg      <= '0;
         tbl_addr_reg <= '0;
      end else if (start_run) begin
         idx_reg      <= '0;
         tbl_addr_reg <= '0;
      end else begin
         if (state_reg == FETCH) begin
            entry_reg.instr <= tbl_instr;
            entry_reg.rd    <= tbl_rd;
            entry_reg.exp   <= tbl_exp;
            entry_reg.chk   <= tbl_chk;
            if (idx_reg != LAST) begin
               tbl_addr_reg <= idx_reg + AW'(1);
            end
         end
         if ((state_reg == NEXT) && (idx_reg != LAST)) begin
            idx_reg <= idx_reg + AW'(1);
         end
      end
   end

   // Result capture: first failure details once, saturating failure count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_count_reg   <= '0;
         fail_idx_reg     <= '0;
         fail_got_reg     <= '0;
         fail_timeout_reg <= 1'b0;
      end else if (start_run) begin
         fail_count_reg   <= '0;
         fail_idx_reg     <= '0;
         fail_got_reg     <= '0;
         fail_timeout_reg <= 1'b0;
      end else if (fail_ev) begin
         if (fail_count_reg == '0) begin
            fail_idx_reg     <= idx_reg;
            fail_got_reg     <= fail_val;
            fail_timeout_reg <= fail_to;
         end
         if (fail_count_reg != FCW'(NUM_TESTS)) begin
            fail_count_reg <= fail_count_reg + FCW'(1);
         end
      end
   end

`ifdef SELFTEST_FAIL_LOG_EN
   selftest_fail_log #(
      .DEPTH (LOG_DEPTH),
      .W     (AW + 1 + XLEN)
   ) u_fail_log (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_run),
      .push  (fail_ev),
      .din   ({idx_reg, fail_to, fail_val}),
      .rd_en (log_rd_en),
      .empty (log_empty),
      .dout  (log_data),
      .ovf   (log_ovf)
   );
`endif

endmodule
